// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default widths and Gray/binary conversion.
package fifo_pkg;

  localparam int unsigned DefPtrWidth  = 3;
  localparam int unsigned DefDataWidth = 8;

  // Conversion helpers operate on a fixed-size container; `width` selects the live bits.
  localparam int unsigned MaxPtrWidth = 32;

  function automatic logic [MaxPtrWidth-1:0] width_mask(input int unsigned width);
    return MaxPtrWidth'((64'(1) << width) - 64'(1));
  endfunction

  function automatic logic [MaxPtrWidth-1:0] bin2gray(input logic [MaxPtrWidth-1:0] bin,
                                                      input int unsigned width);
    return (bin ^ (bin >> 1)) & width_mask(width);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [MaxPtrWidth-1:0] gray2bin(input logic [MaxPtrWidth-1:0] gray,
                                                      input int unsigned width);
    logic [MaxPtrWidth-1:0] g;
    logic [MaxPtrWidth-1:0] bin;
    g   = gray & width_mask(width);
    bin = g;
    for (int unsigned i = 1; i < width; i++) begin
      bin = bin ^ (g >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_port_if.sv
// Read-port bundle: write-pointer crossing, memory read port and the dout handshake.
interface fifo_rd_port_if #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DefDataWidth,
  parameter int unsigned PTR_WIDTH  = fifo_pkg::DefPtrWidth
);

  logic [PTR_WIDTH:0]    g_wptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [PTR_WIDTH:0]    b_rptr;
  logic [PTR_WIDTH:0]    g_rptr;
  logic                  empty;
  logic [PTR_WIDTH:0]    rd_count;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;

  // Read controller side.
  modport master (
    input  g_wptr, mem_rdata, dout_ready,
    output b_rptr, g_rptr, empty, rd_count, dout, dout_valid
  );

  // Memory / write domain / consumer side.
  modport slave (
    output g_wptr, mem_rdata, dout_ready,
    input  b_rptr, g_rptr, empty, rd_count, dout, dout_valid
  );

endinterface

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the rclk domain.
module ptr_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the pointer through the flop chain; stage 0 is the metastability catcher.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_port.sv
// Read-side controller of the async FIFO: empty/occupancy, read pointers and dout stage.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned PTR_WIDTH   = DefPtrWidth,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic          rclk,
  input logic          rrst_n,
  fifo_rd_port_if.master rd
);

  localparam int unsigned PW = PTR_WIDTH + 1;

  if (DEPTH != (1 << PTR_WIDTH)) begin : g_bad_depth
    $error("fifo_rd_port: DEPTH must equal 2**PTR_WIDTH");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_rd_port: SYNC_STAGES must be at least 2");
  end

  logic [PW-1:0]         wq_gptr;
  logic [PW-1:0]         wq_bptr;
  logic [PW-1:0]         b_rptr_q, b_rptr_d, b_rptr_inc;
  logic [PW-1:0]         g_rptr_q, g_rptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  empty;
  logic                  pop;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .async_in (rd.g_wptr),
    .sync_out (wq_gptr)
  );

  // Status derived from registers only; no combinational path from any input.
  always_comb begin
    wq_bptr    = PW'(gray2bin(MaxPtrWidth'(wq_gptr), PW));
    empty      = (g_rptr_q == wq_gptr);
    b_rptr_inc = b_rptr_q + PW'(1);
  end

  // Pop when a word is available and the output stage is free or draining this cycle.
  always_comb begin
    pop          = !empty && (!dout_valid_q || rd.dout_ready);
    b_rptr_d     = b_rptr_q;
    g_rptr_d     = g_rptr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (pop) begin
      dout_d       = rd.mem_rdata;
      dout_valid_d = 1'b1;
      b_rptr_d     = b_rptr_inc;
      g_rptr_d     = PW'(bin2gray(MaxPtrWidth'(b_rptr_inc), PW));
    end else if (dout_valid_q && rd.dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // Read pointers and output stage; reset discards any word held in dout.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr_q     <= '0;
      g_rptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      b_rptr_q     <= b_rptr_d;
      g_rptr_q     <= g_rptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign rd.b_rptr     = b_rptr_q;
  assign rd.g_rptr     = g_rptr_q;
  assign rd.empty      = empty;
  assign rd.rd_count   = wq_bptr - b_rptr_q;
  assign rd.dout       = dout_q;
  assign rd.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed bench for fifo_rd_port with a scoreboard of written words.
module tb_fifo_rd_port;

  logic rclk;
  logic rrst_n;

  fifo_rd_port_if #(.DATA_WIDTH(8), .PTR_WIDTH(3)) rd_if ();

  fifo_rd_port #(
    .DEPTH       (8),
    .DATA_WIDTH  (8),
    .PTR_WIDTH   (3),
    .SYNC_STAGES (2)
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rd     (rd_if)
  );

  logic [7:0] mem [8];
  logic [3:0] wptr;
  logic [7:0] sb_q [$];
  int ntests = 0;
  int nfail  = 0;

  assign rd_if.mem_rdata = mem[rd_if.b_rptr[2:0]];

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model write side: store word, advance pointer, publish Gray pointer, expect the word.
  task automatic wr(input logic [7:0] data);
    mem[wptr[2:0]] = data;
    wptr           = wptr + 4'd1;
    rd_if.g_wptr   = gray4(wptr);
    sb_q.push_back(data);
  endtask

  // Score any transfer happening on the coming edge, then advance one cycle.
  task automatic cyc();
    logic [7:0] exp_d;
    if (rd_if.dout_valid && rd_if.dout_ready) begin
      ntests++;
      assert (sb_q.size() > 0)
      else begin
        nfail++;
        $error("FAIL sb_extra: observed word %0h expected none", rd_if.dout);
      end
      if (sb_q.size() > 0) begin
        exp_d = sb_q.pop_front();
        chk("sb_data", 32'(rd_if.dout), 32'(exp_d));
      end
    end
    @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst_n           = 1'b0;
    rd_if.g_wptr     = '0;
    rd_if.dout_ready = 1'b0;
    wptr             = '0;
    sb_q.delete();
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic drain();
    rd_if.dout_ready = 1'b1;
    for (int i = 0; i < 40 && !(sb_q.size() == 0 && !rd_if.dout_valid); i++) cyc();
    chk("drain_left", 32'(sb_q.size()), 32'd0);
    chk("drain_valid", 32'(rd_if.dout_valid), 32'd0);
    chk("drain_empty", 32'(rd_if.empty), 32'd1);
  endtask

  initial begin
    // Reset with a nonzero write pointer already present.
    rrst_n           = 1'b1;
    rd_if.dout_ready = 1'b0;
    rd_if.g_wptr     = '0;
    wptr             = '0;
    #1 rrst_n = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'h30 + 8'(i));
    chk("rst_gwptr_model", 32'(rd_if.g_wptr), 32'h6);
    #2;
    chk("rst_empty", 32'(rd_if.empty), 32'd1);
    chk("rst_valid", 32'(rd_if.dout_valid), 32'd0);
    chk("rst_brptr", 32'(rd_if.b_rptr), 32'd0);
    chk("rst_count", 32'(rd_if.rd_count), 32'd0);
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    cyc();
    cyc();
    chk("rel_empty", 32'(rd_if.empty), 32'd0);
    chk("rel_count", 32'(rd_if.rd_count), 32'd4);
    drain();

    // Single word, three-edge latency.
    do_reset();
    rd_if.dout_ready = 1'b1;
    wr(8'hA5);
    cyc();
    cyc();
    chk("single_pre_valid", 32'(rd_if.dout_valid), 32'd0);
    cyc();
    chk("single_dout", 32'(rd_if.dout), 32'hA5);
    chk("single_valid", 32'(rd_if.dout_valid), 32'd1);
    chk("single_brptr", 32'(rd_if.b_rptr), 32'd1);
    chk("single_grptr", 32'(rd_if.g_rptr), 32'b0001);
    chk("single_empty", 32'(rd_if.empty), 32'd1);
    cyc();
    chk("single_done", 32'(rd_if.dout_valid), 32'd0);

    // Backpressure: exactly one load while the consumer stalls.
    do_reset();
    wr(8'h41);
    wr(8'h42);
    wr(8'h43);
    cyc();
    cyc();
    cyc();
    chk("bp_valid", 32'(rd_if.dout_valid), 32'd1);
    chk("bp_dout", 32'(rd_if.dout), 32'h41);
    chk("bp_brptr", 32'(rd_if.b_rptr), 32'd1);
    chk("bp_count", 32'(rd_if.rd_count), 32'd2);
    for (int i = 0; i < 3; i++) cyc();
    chk("bp_hold_dout", 32'(rd_if.dout), 32'h41);
    chk("bp_hold_brptr", 32'(rd_if.b_rptr), 32'd1);
    rd_if.dout_ready = 1'b1;
    cyc();
    chk("bp_w2_valid", 32'(rd_if.dout_valid), 32'd1);
    chk("bp_w2_dout", 32'(rd_if.dout), 32'h42);
    cyc();
    chk("bp_w3_valid", 32'(rd_if.dout_valid), 32'd1);
    chk("bp_w3_dout", 32'(rd_if.dout), 32'h43);
    cyc();
    chk("bp_end_valid", 32'(rd_if.dout_valid), 32'd0);

    // Full FIFO, then a second lap across pointer wrap with no bubbles.
    do_reset();
    rd_if.dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i));
    chk("full_gwptr_model", 32'(rd_if.g_wptr), 32'b1100);
    cyc();
    cyc();
    chk("full_count", 32'(rd_if.rd_count), 32'd8);
    for (int lap = 0; lap < 2; lap++) begin
      if (lap == 1) begin
        for (int i = 0; i < 8; i++) wr(8'hC0 + 8'(i));
        cyc();
        cyc();
      end
      for (int i = 0; i < 8; i++) begin
        logic [3:0] exp_b;
        exp_b = 4'(lap * 8 + i + 1);
        cyc();
        chk("wrap_valid", 32'(rd_if.dout_valid), 32'd1);
        chk("wrap_brptr", 32'(rd_if.b_rptr), 32'(exp_b));
        chk("wrap_grptr", 32'(rd_if.g_rptr), 32'(gray4(exp_b)));
      end
      cyc();
      chk("wrap_lap_end", 32'(rd_if.dout_valid), 32'd0);
    end
    chk("wrap_brptr_final", 32'(rd_if.b_rptr), 32'd0);
    chk("wrap_left", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset while a word is held in dout.
    do_reset();
    for (int i = 0; i < 8; i++) wr(8'hE0 + 8'(i));
    cyc();
    cyc();
    cyc();
    rd_if.dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    rd_if.dout_ready = 1'b0;
    chk("ar_pre_valid", 32'(rd_if.dout_valid), 32'd1);
    chk("ar_pre_brptr", 32'(rd_if.b_rptr), 32'd5);
    #2 rrst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(rd_if.dout_valid), 32'd0);
    chk("ar_dout", 32'(rd_if.dout), 32'd0);
    chk("ar_brptr", 32'(rd_if.b_rptr), 32'd0);
    chk("ar_empty", 32'(rd_if.empty), 32'd1);
    do_reset();
    cyc();
    chk("ar_after_valid", 32'(rd_if.dout_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_rd_port.md
# fifo_rd_port

Read-side controller for the dual-clock asynchronous FIFO, running entirely in the read clock domain. It synchronizes the write domain's Gray write pointer and derives `empty` and the read occupancy. It drives the binary read pointer into the FIFO memory, whose read is combinational, and presents data through a registered valid/ready output stage. It also returns its Gray read pointer to the write domain for full detection.

## Interface
Parameters:
- `DEPTH`, 8, number of memory words; must equal 2**`PTR_WIDTH`
- `DATA_WIDTH`, 8, word width
- `PTR_WIDTH`, 3, memory address width; pointers are `PTR_WIDTH`+1 bits
- `SYNC_STAGES`, 2, flops in the write-pointer synchronizer (≥2)

Ports:
- `rclk` in 1: read clock; the only clock in the block
- `rrst_n` in 1: reset, asynchronous, active-low
- `g_wptr` in `PTR_WIDTH`+1: Gray write pointer, registered in the write domain
- `mem_rdata` in `DATA_WIDTH`: memory word at address `b_rptr[PTR_WIDTH-1:0]`, combinational
- `b_rptr` out `PTR_WIDTH`+1: binary read pointer to memory
- `g_rptr` out `PTR_WIDTH`+1: registered Gray read pointer to the write domain
- `empty` out 1: no unread word in memory
- `rd_count` out `PTR_WIDTH`+1: words in memory not yet loaded into `dout`
- `dout` out `DATA_WIDTH`: output data register
- `dout_valid` out 1: `dout` holds a word
- `dout_ready` in 1: consumer accepts `dout` this cycle

## Operation
- Synchronizer: `g_wptr` passes through `SYNC_STAGES` flops to produce `wq_gptr`. No other logic uses `g_wptr` directly.
- `empty` = (`g_rptr` == `wq_gptr`). This is combinational from registers only.
- `rd_count` = gray2bin(`wq_gptr`) − `b_rptr`, computed modulo 2^(`PTR_WIDTH`+1). Range is 0..`DEPTH`.
- `pop` = !`empty` & (!`dout_valid` | `dout_ready`).
- On `pop`:
  - `dout` <= `mem_rdata`
  - `dout_valid` <= 1
  - `b_rptr` <= `b_rptr`+1
  - `g_rptr` <= bin2gray(`b_rptr`+1)
- Else, if `dout_valid` & `dout_ready`: `dout_valid` <= 0. `dout` holds its value.
- With `dout_valid`=1 and `dout_ready`=0, `dout`, `b_rptr` and `g_rptr` hold.
- Wrap-around: pointers wrap naturally from 2·`DEPTH`−1 to 0. The MSB distinguishes lap. `rd_count` = `DEPTH` when the pointers differ only in MSB after Gray-to-binary conversion.
- Simultaneous accept and non-empty: the next word loads in the same edge, giving back-to-back throughput of one word per cycle.
- Underflow is impossible by construction: no pop occurs while `empty`=1.
- Reset values: `b_rptr`=0, `g_rptr`=0, synchronizer flops=0, `dout`=0, `dout_valid`=0. Hence `empty`=1 and `rd_count`=0.
- Reset mid-operation: all state clears immediately, without a clock edge. Any word in `dout` is discarded. The write domain is reset in the same event; behaviour under a one-sided reset is undefined.

## Timing
- Suppose `g_wptr` changes and is stable before `rclk` edge N (`SYNC_STAGES`=2):
  - `wq_gptr` updates after edge N+1, so `empty` falls after N+1.
  - `dout_valid` rises after edge N+2.
- Write-to-read latency is therefore `SYNC_STAGES`+1 `rclk` edges.
- `g_rptr` updates in the same edge as the pop. The write domain sees it after its own synchronizer.
- `dout` and `dout_valid` are direct flop outputs. `empty` and `rd_count` are flop-driven combinational outputs with no input-to-output path.
- A transfer completes on any `rclk` edge with `dout_valid` & `dout_ready`.

## Structure
- Shared package `fifo_pkg`:
  - functions `bin2gray` and `gray2bin`, parameterized by width
  - default `PTR_WIDTH`/`DATA_WIDTH` constants, shared with the write side and `fifo_mem`
- One sub-module, `ptr_sync`: a `SYNC_STAGES`-deep flop chain with parameters WIDTH and STAGES, clock `rclk`, async active-low reset. The write side instantiates it too.

## Test plan
- Reset: `rrst_n`=0 while `g_wptr`=4'b0110 → `empty`=1, `dout_valid`=0, `b_rptr`=0, `rd_count`=0. Hold until 2 edges after release, then `empty`=0 and `rd_count`=4.
- Single word: `g_wptr` 0000→0001, `mem_rdata`=8'hA5, `dout_ready`=1 → after the 3rd edge `dout`=8'hA5 and `dout_valid`=1, `b_rptr`=1, `g_rptr`=0001, `empty`=1. On the next edge `dout_valid`=0.
- Backpressure: `g_wptr`=gray(3)=0010, `dout_ready`=0 → exactly one load; `dout` stable; `b_rptr`=1; `rd_count`=2. Then raise `dout_ready` → two further words on consecutive edges, then `dout_valid`=0.
- Full and wrap: `g_wptr`=gray(8)=1100 from reset → `rd_count`=8. Drain with ready held high, then feed 8 more words → `b_rptr` goes 1111→0000, `g_rptr` goes 1000→0000, and all 16 words emerge in order with no gaps.
- Async reset mid-stream: `dout_valid`=1, `b_rptr`=5, drop `rrst_n` between edges → `dout_valid`, `dout` and `b_rptr` are 0 before the next `rclk` edge.
